// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN input-feature-map datapath.
// The window side is fixed at 3, so one window feeds a 9-element PE array.
package cnn_pkg;

  localparam int INPUT_WIDTH = 8;
  localparam int K           = 3;
  localparam int PE_ARR_SIZE = K * K;

  typedef logic signed [INPUT_WIDTH-1:0] pixel_t;
  typedef pixel_t window_t [PE_ARR_SIZE];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH
  } wb_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage with a combinational read port.
// A write at the same index as the read returns the old word, so the caller sees the previous row.
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rd_data = r_mem[i_addr];

  // NOTE: storage is deliberately left out of reset; a row only reaches a
  // valid window after it has been rewritten in the current frame.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/ifm_window_buffer.sv
// Turns a raster-order pixel stream into 3x3 sliding windows (valid convolution,
// stride 1) with a valid/ready handshake on both sides.
module ifm_window_buffer
  import cnn_pkg::*;
#(
  parameter int INPUT_WIDTH = cnn_pkg::INPUT_WIDTH,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int K           = cnn_pkg::K
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          pix_valid,
  input  logic signed [INPUT_WIDTH-1:0] pix_in,
  output logic                          pix_ready,
  input  logic                          win_ready,
  output logic                          win_valid,
  output logic signed [INPUT_WIDTH-1:0] win_out [K*K],
  output logic                          frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  wb_state_e                     r_state;
  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic signed [INPUT_WIDTH-1:0] r_win [K*K];
  logic                          r_win_valid;
  logic                          r_frame_done;

  logic                          w_accept;
  logic                          w_qualify;
  logic                          w_last_pix;
  logic [INPUT_WIDTH-1:0]        w_line1_rd;
  logic [INPUT_WIDTH-1:0]        w_line2_rd;
  logic signed [INPUT_WIDTH-1:0] w_new_col [K];

  // Ready must see win_ready in the same cycle so a handoff and a new
  // acceptance can share one edge, giving one window per cycle.
  assign pix_ready  = (r_state == ST_STREAM) && (!r_win_valid || win_ready);
  assign w_accept   = pix_valid && pix_ready;
  assign w_qualify  = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // line1 holds row r-1; its old word moves into line2, which holds row r-2.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (INPUT_WIDTH),
    .AW    (CW)
  ) u_line1 (
    .clk       (clk),
    .i_we      (w_accept),
    .i_addr    (r_col),
    .i_wr_data (pix_in),
    .o_rd_data (w_line1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (INPUT_WIDTH),
    .AW    (CW)
  ) u_line2 (
    .clk       (clk),
    .i_we      (w_accept),
    .i_addr    (r_col),
    .i_wr_data (w_line1_rd),
    .o_rd_data (w_line2_rd)
  );

  assign w_new_col[K-3] = w_line2_rd;
  assign w_new_col[K-2] = w_line1_rd;
  assign w_new_col[K-1] = pix_in;

  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;
  assign win_out    = r_win;

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < K*K; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_STREAM;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            for (int i = 0; i < K*K; i++) begin
              r_win[i] <= '0;
            end
          end
        end

        ST_STREAM: begin
          if (w_accept) begin
            for (int rr = 0; rr < K; rr++) begin
              for (int cc = 0; cc < K-1; cc++) begin
                r_win[rr*K + cc] <= r_win[rr*K + cc + 1];
              end
              r_win[rr*K + K - 1] <= w_new_col[rr];
            end

            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end

            // Columns 0..K-2 of a row leave valid low, so the previous
            // row's tail in the shift register is never presented.
            r_win_valid  <= w_qualify;
            r_frame_done <= w_last_pix;
            if (w_last_pix) begin
              r_state <= ST_FLUSH;
            end
          end else if (win_ready) begin
            r_win_valid <= 1'b0;
          end
        end

        ST_FLUSH: begin
          if (!r_win_valid || win_ready) begin
            r_win_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_window_buffer.sv
// Bench for ifm_window_buffer: a 4x4 and a 5x3 instance, expected windows taken
// from a stored copy of each frame and queued at acceptance, popped at handoff.
module tb_ifm_window_buffer;
  import cnn_pkg::*;

  localparam int W_A = 4;
  localparam int H_A = 4;
  localparam int W_B = 5;
  localparam int H_B = 3;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start [2];
  logic   pv    [2];
  pixel_t pin   [2];
  logic   pr    [2];
  logic   wr    [2];
  logic   wv    [2];
  logic   fd    [2];
  pixel_t wo_a  [PE_ARR_SIZE];
  pixel_t wo_b  [PE_ARR_SIZE];

  int     n_cmp = 0;
  int     n_err = 0;
  pixel_t q0 [$];
  pixel_t q1 [$];
  int     img     [2][64];
  int     cr      [2];
  int     cc      [2];
  int     win_cnt [2];
  int     fd_cnt  [2];

  pixel_t mon_got;
  pixel_t mon_exp;
  int     mon_bad;

  always #5 clk = ~clk;

  ifm_window_buffer #(
    .INPUT_WIDTH (8),
    .IMG_W       (W_A),
    .IMG_H       (H_A),
    .K           (3)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start[0]),
    .pix_valid  (pv[0]),
    .pix_in     (pin[0]),
    .pix_ready  (pr[0]),
    .win_ready  (wr[0]),
    .win_valid  (wv[0]),
    .win_out    (wo_a),
    .frame_done (fd[0])
  );

  ifm_window_buffer #(
    .INPUT_WIDTH (8),
    .IMG_W       (W_B),
    .IMG_H       (H_B),
    .K           (3)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start[1]),
    .pix_valid  (pv[1]),
    .pix_in     (pin[1]),
    .pix_ready  (pr[1]),
    .win_ready  (wr[1]),
    .win_valid  (wv[1]),
    .win_out    (wo_b),
    .frame_done (fd[1])
  );

  // Scoreboard side: a handoff happens at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    #3;
    for (int s = 0; s < 2; s++) begin
      if (wv[s] === 1'b1 && wr[s] === 1'b1) begin
        win_cnt[s]++;
        n_cmp++;
        if (((s == 0) ? q0.size() : q1.size()) < PE_ARR_SIZE) begin
          n_err++;
          $display("FAIL unexpected_window dut%0d: got window #%0d, required none queued", s, win_cnt[s]);
        end else begin
          mon_bad = -1;
          for (int k = 0; k < PE_ARR_SIZE; k++) begin
            mon_got = (s == 0) ? wo_a[k] : wo_b[k];
            mon_exp = (s == 0) ? q0.pop_front() : q1.pop_front();
            if (mon_got !== mon_exp && mon_bad < 0) begin
              mon_bad = k;
              n_err++;
              $display("FAIL window_data dut%0d win#%0d idx%0d: got %0d, required %0d",
                       s, win_cnt[s], k, mon_got, mon_exp);
            end
          end
        end
      end
      if (fd[s] === 1'b1) fd_cnt[s]++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic bit win_is_zero(input int sel);
    for (int k = 0; k < PE_ARR_SIZE; k++) begin
      if (((sel == 0) ? wo_a[k] : wo_b[k]) !== 8'sd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Present one pixel, wait (bounded) for acceptance, queue any window it
  // completes, then check latency and frame_done one cycle later.
  task automatic send(input int sel, input int v, input int gap, input int stall);
    int     w, h, tries, idx;
    bit     qual, last, held;
    pixel_t snap [PE_ARR_SIZE];
    w = (sel == 0) ? W_A : W_B;
    h = (sel == 0) ? H_A : H_B;
    pv[sel]  = 1'b1;
    pin[sel] = pixel_t'(v);
    #1;
    tries = 0;
    while (pr[sel] !== 1'b1) begin
      if (tries == 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL pix_ready_timeout dut%0d: got %b, required 1", sel, pr[sel]);
        pv[sel] = 1'b0;
        return;
      end
      tries++;
      @(negedge clk);
      #3;
    end
    img[sel][cr[sel]*w + cc[sel]] = v;
    qual = (cr[sel] >= 2) && (cc[sel] >= 2);
    last = (cr[sel] == h-1) && (cc[sel] == w-1);
    if (qual) begin
      for (int k = 0; k < PE_ARR_SIZE; k++) begin
        idx = (cr[sel] - 2 + k/3)*w + (cc[sel] - 2 + k%3);
        if (sel == 0) q0.push_back(pixel_t'(img[sel][idx]));
        else          q1.push_back(pixel_t'(img[sel][idx]));
      end
    end
    @(negedge clk);
    #2;
    pv[sel] = 1'b0;
    n_cmp++;
    if (wv[sel] !== qual) begin
      n_err++;
      $display("FAIL win_valid_latency dut%0d r%0d c%0d: got %b, required %b", sel, cr[sel], cc[sel], wv[sel], qual);
    end
    n_cmp++;
    if (fd[sel] !== last) begin
      n_err++;
      $display("FAIL frame_done dut%0d r%0d c%0d: got %b, required %b", sel, cr[sel], cc[sel], fd[sel], last);
    end
    if (cc[sel] == w-1) begin
      cc[sel] = 0;
      cr[sel]++;
    end else begin
      cc[sel]++;
    end

    if (stall > 0) begin
      wr[sel] = 1'b0;
      for (int k = 0; k < PE_ARR_SIZE; k++) snap[k] = (sel == 0) ? wo_a[k] : wo_b[k];
      pv[sel]  = 1'b1;
      pin[sel] = 8'sd127;
      repeat (stall) begin
        @(negedge clk);
        #2;
        held = 1'b1;
        for (int k = 0; k < PE_ARR_SIZE; k++) begin
          if (((sel == 0) ? wo_a[k] : wo_b[k]) !== snap[k]) held = 1'b0;
        end
        n_cmp++;
        if (wv[sel] !== 1'b1 || pr[sel] !== 1'b0 || !held) begin
          n_err++;
          $display("FAIL stall_hold dut%0d: got valid=%b ready=%b held=%b, required valid=1 ready=0 held=1",
                   sel, wv[sel], pr[sel], held);
        end
      end
      wr[sel] = 1'b1;
      pv[sel] = 1'b0;
    end

    repeat (gap) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Whole frame: start pulse, all pixels, drain, then count checks.
  task automatic run_frame(input int sel, input int base, input bit rnd,
                           input int gap, input int stall, input int mid_start);
    int w, h, v, tries, exp_n;
    w     = (sel == 0) ? W_A : W_B;
    h     = (sel == 0) ? H_A : H_B;
    exp_n = (h - 2)*(w - 2);
    start[sel] = 1'b1;
    @(negedge clk);
    #2;
    start[sel]   = 1'b0;
    cr[sel]      = 0;
    cc[sel]      = 0;
    win_cnt[sel] = 0;
    fd_cnt[sel]  = 0;
    n_cmp++;
    if (pr[sel] !== 1'b1 || wv[sel] !== 1'b0 || !win_is_zero(sel)) begin
      n_err++;
      $display("FAIL start_state dut%0d: got ready=%b valid=%b zero_win=%b, required 1 0 1",
               sel, pr[sel], wv[sel], win_is_zero(sel));
    end
    for (int i = 0; i < w*h; i++) begin
      v = rnd ? (int'($urandom_range(0, 255)) - 128) : (base + i);
      if (i == mid_start) start[sel] = 1'b1;
      send(sel, v, gap, (i == 2*w + 2) ? stall : 0);
      start[sel] = 1'b0;
    end
    tries = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && tries < 20) begin
      @(negedge clk);
      #2;
      tries++;
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (win_cnt[sel] !== exp_n) begin
      n_err++;
      $display("FAIL window_count dut%0d: got %0d, required %0d", sel, win_cnt[sel], exp_n);
    end
    n_cmp++;
    if (fd_cnt[sel] !== 1) begin
      n_err++;
      $display("FAIL frame_done_count dut%0d: got %0d, required 1", sel, fd_cnt[sel]);
    end
    n_cmp++;
    if (((sel == 0) ? q0.size() : q1.size()) != 0) begin
      n_err++;
      $display("FAIL windows_missing dut%0d: got %0d pixels left, required 0",
               sel, (sel == 0) ? q0.size() : q1.size());
    end
    n_cmp++;
    if (wv[sel] !== 1'b0 || pr[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_frame dut%0d: got valid=%b ready=%b, required 0 0", sel, wv[sel], pr[sel]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
    end
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (pr[s] !== 1'b0 || wv[s] !== 1'b0 || fd[s] !== 1'b0 || !win_is_zero(s)) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got ready=%b valid=%b done=%b zero_win=%b, required 0 0 0 1",
                 s, pr[s], wv[s], fd[s], win_is_zero(s));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    #2;
  endtask

  task automatic test_stream_basic();
    run_frame(0, 0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    run_frame(0, 0, 1'b0, 0, 3, -1);
  endtask

  task automatic test_pixel_gaps();
    run_frame(0, 0, 1'b0, 1, 0, -1);
  endtask

  task automatic test_reset_mid_frame();
    start[0] = 1'b1;
    @(negedge clk);
    #2;
    start[0] = 1'b0;
    cr[0] = 0;
    cc[0] = 0;
    for (int i = 0; i < 8; i++) send(0, 40 + i, 0, 0);
    rst_n    = 1'b0;
    start[0] = 1'b1;
    pv[0]    = 1'b1;
    pin[0]   = 8'sd99;
    @(negedge clk);
    #2;
    n_cmp++;
    if (pr[0] !== 1'b0 || wv[0] !== 1'b0 || fd[0] !== 1'b0 || !win_is_zero(0)) begin
      n_err++;
      $display("FAIL reset_mid_frame: got ready=%b valid=%b done=%b zero_win=%b, required 0 0 0 1",
               pr[0], wv[0], fd[0], win_is_zero(0));
    end
    rst_n    = 1'b1;
    start[0] = 1'b0;
    pv[0]    = 1'b0;
    @(negedge clk);
    #2;
    n_cmp++;
    if (pr[0] !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got ready=%b, required 0", pr[0]);
    end
    run_frame(0, 0, 1'b1, 0, 0, -1);
  endtask

  task automatic test_start_ignored();
    run_frame(0, 0, 1'b0, 0, 0, 6);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, 1'b1, 0, 0, -1);
    run_frame(0, -100, 1'b0, 0, 0, -1);
  endtask

  task automatic test_narrow_frame();
    run_frame(1, 0, 1'b0, 0, 0, -1);
    run_frame(1, 0, 1'b1, 1, 2, -1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start[s]   = 1'b0;
      pv[s]      = 1'b0;
      pin[s]     = '0;
      wr[s]      = 1'b1;
      cr[s]      = 0;
      cc[s]      = 0;
      win_cnt[s] = 0;
      fd_cnt[s]  = 0;
    end
    rst_n = 1'b0;
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_pixel_gaps();
    test_reset_mid_frame();
    test_start_ignored();
    test_back_to_back();
    test_narrow_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifm_window_buffer.md
IFM_WINDOW_BUFFER -- requirements
Module: ifm_window_buffer

Interface
REQ-001 Parameter INPUT_WIDTH, default 8, signed pixel width; matches PE array ifm width.
REQ-002 Parameter IMG_W, default 32, pixels per row (>=3).
REQ-003 Parameter IMG_H, default 32, rows per frame (>=3).
REQ-004 Parameter K, default 3, window side; fixed 3, window size K*K=9 = PE array size.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle pulse; begins a frame.
REQ-008 pix_valid  input  1  pix_in holds a valid raster-order pixel.
REQ-009 pix_in  input  INPUT_WIDTH (signed)  input pixel.
REQ-010 pix_ready  output  1  pixel accepted this cycle when pix_valid && pix_ready.
REQ-011 win_ready  input  1  downstream can take a window.
REQ-012 win_valid  output  1  win_out holds a complete 3x3 window; drives PE array ready_load.
REQ-013 win_out  output  array[9] of INPUT_WIDTH (signed)  window, row-major, index 0 = top-left, index 8 = newest pixel.
REQ-014 frame_done  output  1  one-cycle pulse with last window of frame.

Function
REQ-015 FSM states IDLE, STREAM, FLUSH; IDLE->STREAM on start; STREAM->FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1); FLUSH->IDLE when final window handed off (win_valid && win_ready).
REQ-016 start SHALL clear col/row counters and window registers; start outside IDLE ignored.
REQ-017 pix_ready = (state==STREAM) && (!win_valid || win_ready); low in IDLE and FLUSH.
REQ-018 Two line buffers, depth IMG_W, hold rows r-1 and r-2; on acceptance each column shifts one row up.
REQ-019 3x3 shift register shifts left on every acceptance; new column = {line2[c], line1[c], pix_in}.
REQ-020 Window for accepted pixel (r,c) valid iff r>=2 and c>=2; covers rows r-2..r, cols c-2..c.
REQ-021 Latency: win_valid and win_out registered, asserted the cycle after the accepting edge.
REQ-022 win_valid && !win_ready: win_out and win_valid held stable, no pixel accepted.
REQ-023 win_valid clears after handoff unless a new qualifying pixel is accepted the same cycle (back-to-back windows at 1/cycle).
REQ-024 Row wrap: col counter wraps IMG_W-1->0 and increments row; cols 0,1 of each row produce no window; stale columns from previous row never appear in a valid window.
REQ-025 Windows per frame = (IMG_H-2)*(IMG_W-2), exactly.
REQ-026 frame_done pulses one cycle, coincident with first cycle win_valid is high for pixel (IMG_H-1, IMG_W-1).
REQ-027 Pixel gaps (pix_valid low) stall counters and shift state; no effect on output ordering.
REQ-028 Pixels are passed unmodified; no arithmetic, no padding (valid convolution only).

Reset
REQ-029 rst_n low at clk edge: state=IDLE, counters=0, win_valid=0, frame_done=0, pix_ready=0, win_out all 0; takes priority over start and any handshake, including mid-frame.
REQ-030 Line buffer contents need not be reset; must not be visible before being rewritten in a new frame.

Structure
REQ-031 Shared package cnn_pkg holds INPUT_WIDTH, K, PE_ARR_SIZE (=K*K), pixel_t signed typedef, window_t array typedef, FSM state enum.
REQ-032 One sub-module line_buffer (depth IMG_W, width INPUT_WIDTH, read-before-write at the same index), instantiated twice.

Verification
REQ-033 IMG_W=IMG_H=4, pixels 0..15 continuous, win_ready=1 -> 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}; frame_done with last.
REQ-034 Same frame, win_ready low 3 cycles at first window -> win_out held, pix_ready=0, no pixel lost; same 4 windows.
REQ-035 pix_valid toggled every other cycle -> identical window sequence, latency 1 cycle from each qualifying acceptance.
REQ-036 rst_n low after pixel 7 -> all outputs 0 next cycle, state IDLE; new start + full frame -> correct 4 windows, no stale data.
REQ-037 start pulsed mid-frame -> ignored; window count remains 4.
REQ-038 IMG_W=5, IMG_H=3, ramp 0..14 -> 3 windows, first {0,1,2,5,6,7,10,11,12}; no window at cols 0,1.
